// File: rtl/controle_estoque_rolhas.sv
// rtl/controle_estoque_rolhas.sv - cork stock counter with supervised refill exchange
// Optional macro CONTADOR_GARRAFAS_EN enables the 16-bit TOTAL_VEDADAS seal counter.
module controle_estoque_rolhas #(
    parameter int W          = 5,
    parameter int MAX_ROLHAS = 20,
    parameter int LIMIAR_MIN = 5,
    parameter int TIMEOUT    = 1000,
    parameter int TW         = 10
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         DECREMENTA_ROLHA,
    input  logic         ADICIONA_ROLHA,
    input  logic         LIMPA_FALHA,
    output logic [W-1:0] ESTOQUE,
    output logic         ROLHAS_DISPONIVEIS,
    output logic         ESTOQUE_BAIXO,
    output logic         REQ_REPOSICAO,
    output logic         FALHA_REPOSICAO,
    output logic         ERRO_SUBFLUXO,
    output logic [15:0]  TOTAL_VEDADAS
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        REPONDO = 2'd1,
        FALHA   = 2'd2
    } estado_t;

    localparam logic [W-1:0]  MAX_W       = W'(MAX_ROLHAS);
    localparam logic [W-1:0]  LIMIAR_W    = W'(LIMIAR_MIN);
    localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT - 1);

    estado_t       estado;
    logic [TW-1:0] timer;
    logic [W-1:0]  estoque_prox;
    logic          soma;
    logic          subtrai;
    logic          subfluxo;

    // Simultaneous DEC and ADD cancel out: the seal is still accepted.
    assign soma     = ADICIONA_ROLHA && !DECREMENTA_ROLHA && (ESTOQUE != MAX_W);
    assign subtrai  = DECREMENTA_ROLHA && !ADICIONA_ROLHA && (ESTOQUE != '0);
    assign subfluxo = DECREMENTA_ROLHA && !ADICIONA_ROLHA && (ESTOQUE == '0);

    always_comb begin
        estoque_prox = ESTOQUE;
        if (soma) begin
            estoque_prox = ESTOQUE + W'(1);
        end else if (subtrai) begin
            estoque_prox = ESTOQUE - W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ESTOQUE       <= '0;
            ERRO_SUBFLUXO <= 1'b0;
        end else begin
            ESTOQUE <= estoque_prox;
            if (subfluxo) begin
                ERRO_SUBFLUXO <= 1'b1;
            end else if (LIMPA_FALHA) begin
                ERRO_SUBFLUXO <= 1'b0;
            end
        end
    end

    // Reaching full stock takes precedence over the refill timeout.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            estado <= NORMAL;
            timer  <= '0;
        end else begin
            case (estado)
                NORMAL: begin
                    if (ESTOQUE <= LIMIAR_W) begin
                        estado <= REPONDO;
                        timer  <= '0;
                    end
                end
                REPONDO: begin
                    if (estoque_prox == MAX_W) begin
                        estado <= NORMAL;
                    end else if (ADICIONA_ROLHA) begin
                        timer <= '0;
                    end else if (timer == TIMEOUT_FIM) begin
                        estado <= FALHA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                FALHA: begin
                    if (LIMPA_FALHA) begin
                        estado <= NORMAL;
                    end
                end
                default: begin
                    estado <= NORMAL;
                end
            endcase
        end
    end

    assign ROLHAS_DISPONIVEIS = (ESTOQUE != '0);
    assign ESTOQUE_BAIXO      = (ESTOQUE <= LIMIAR_W);
    assign REQ_REPOSICAO      = (estado == REPONDO);
    assign FALHA_REPOSICAO    = (estado == FALHA);

`ifdef CONTADOR_GARRAFAS_EN
    logic        aceita;
    logic [15:0] total;

    assign aceita = DECREMENTA_ROLHA && !subfluxo;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            total <= 16'd0;
        end else if (aceita) begin
            total <= total + 16'd1;
        end
    end

    assign TOTAL_VEDADAS = total;
`else
    assign TOTAL_VEDADAS = 16'd0;
`endif

endmodule
